uart_text_buffer: RTL and testbench
===================================

Name: uart_text_buffer

Overview:
- Consumer of the UART receive path's char/en stream; sits between the UART wrapper and the VGA text renderer.
- Keeps a ROWS x COLS character RAM plus a cursor.
- Incoming characters are written at the cursor; CR (13) starts a new cleared line; NUL (0) clears the whole screen.
- The renderer reads the RAM through an independent synchronous read port.

Parameters:
COLS, 40, characters per row
ROWS, 15, rows on screen
COL_W, 6, width of column indices (must satisfy 2^COL_W >= COLS)
ROW_W, 4, width of row indices (must satisfy 2^ROW_W >= ROWS)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous, active-low reset
char  input  8  received character from UART wrapper
en  input  1  one-cycle strobe, char valid
rd_row  input  ROW_W  renderer read row
rd_col  input  COL_W  renderer read column
rd_char  output  8  RAM contents at (rd_row,rd_col), registered
cursor_row  output  ROW_W  current cursor row
cursor_col  output  COL_W  current cursor column
busy  output  1  line/screen clear in progress
overflow  output  1  sticky: a character was dropped

Behaviour:
- Reset (async assert, sync release):
  - rd_char=0, cursor=(0,0), overflow=0, pending slot empty.
  - State=CLR_ALL with clear address 0, so busy=1 immediately after reset.
  - RAM is not reset; CLR_ALL fills it.
- States: IDLE, CLR_LINE, CLR_ALL. busy=1 in CLR_LINE/CLR_ALL.
- Blank character is 32 (space).
- CLR_ALL:
  - Writes 32 to one address per cycle, row-major from (0,0) to (ROWS-1,COLS-1): ROWS*COLS cycles.
  - Then goes to IDLE; cursor forced to (0,0) on entry.
- CLR_LINE:
  - Writes 32 to (cursor_row,0..COLS-1): COLS cycles, then IDLE.
- Character processing in IDLE (one character per cycle):
  - Source is the pending slot if valid, else en/char.
  - Printable (any value other than 0 and 13):
    - RAM[cursor] <= char.
    - If cursor_col < COLS-1: cursor_col+1, stay IDLE.
    - Else: newline.
  - 13 (CR): newline.
  - 0 (NUL): enter CLR_ALL, overflow cleared.
  - Newline:
    - cursor_col=0.
    - cursor_row=(cursor_row==ROWS-1)?0:cursor_row+1 (wrap, no scroll).
    - Enter CLR_LINE for the new row.
- Pending slot (1 deep):
  - en while busy: if the slot is empty, capture char into it.
  - en while busy with the slot full: character is dropped and overflow<=1.
  - First IDLE cycle: the pending char is processed and the slot freed. An en arriving in that same cycle is captured into the slot, not dropped.
  - en in IDLE with the slot empty: processed directly, zero wait.
- Simultaneous events: an en on the cycle a clear finishes is captured into the slot (busy still 1 that cycle) if the slot is empty.
- Read port:
  - rd_char is registered, 1-cycle latency: address presented at edge N, data valid after edge N+1.
  - Independent of state.
  - Same-address collision returns old data (read-before-write).
- Write-to-read visibility:
  - en at cycle N in IDLE writes at edge N.
  - A read of that address issued in cycle N+1 returns the new char.
- Overflow: sticky; cleared only by reset or by processing a NUL.
- Reset mid-clear: aborts immediately and restarts CLR_ALL from address 0. The pending slot is discarded.

Test Plan:
- Reset, hold 600 cycles; read all 600 addresses -> every rd_char=32, busy falls after exactly 600 cycles, cursor=(0,0).
- Send 'H'(72),'i'(105) in IDLE -> RAM(0,0)=72, RAM(0,1)=105, cursor=(0,2), busy never asserted.
- Send 41 printable chars from (0,0) -> 41st lands at (1,0) after a 40-cycle CLR_LINE of row 1; cursor=(1,1).
- Send 13 with cursor on row 14 -> cursor=(0,0), row 0 all 32 after 40 cycles, rows 1-14 unchanged.
- During CLR_LINE send 'A'(65) then 'B'(66) -> 'A' written at (row,0) on first IDLE cycle, 'B' dropped, overflow=1; then send 0 -> overflow=0, full clear of 600 cycles.
- Deassert rst_n mid-CLR_LINE with the pending slot full -> outputs at reset values immediately, slot empty, CLR_ALL restarts at address 0.

Source files
------------

// File: rtl/uart_text_buffer.sv
// rtl/uart_text_buffer.sv - character RAM and cursor fed by the UART receive stream
//
// Purpose:
//   Holds a ROWS x COLS screen of characters. Each received character is
//   written at the cursor: CR (13) moves to a freshly blanked line, NUL (0)
//   blanks the whole screen. A one-deep pending slot absorbs a character
//   that arrives while a clear is running. The renderer reads the RAM
//   through an independent registered read port.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   char, en    received character and its one-cycle valid strobe
//   rd_row/col  renderer read address
//   rd_char     RAM contents at the read address, one cycle later
//   cursor_*    current cursor position
//   busy        a line or screen clear is in progress
//   overflow    sticky: a character was dropped
module uart_text_buffer #(
    parameter int COLS  = 40,
    parameter int ROWS  = 15,
    parameter int COL_W = 6,
    parameter int ROW_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       char,
    input  logic             en,
    input  logic [ROW_W-1:0] rd_row,
    input  logic [COL_W-1:0] rd_col,
    output logic [7:0]       rd_char,
    output logic [ROW_W-1:0] cursor_row,
    output logic [COL_W-1:0] cursor_col,
    output logic             busy,
    output logic             overflow
);

    localparam int DEPTH = ROWS * COLS;
    localparam int AW    = $clog2(DEPTH);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [7:0]       BLANK    = 8'd32;
    localparam logic [7:0]       CH_CR    = 8'd13;
    localparam logic [7:0]       CH_NUL   = 8'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLR_LINE,
        S_CLR_ALL
    } state_t;

    function automatic logic [AW-1:0] addr_of(input logic [ROW_W-1:0] row,
                                              input logic [COL_W-1:0] col);
        return AW'(row) * AW'(COLS) + AW'(col);
    endfunction

    state_t           r_state, w_state_nxt;
    logic [ROW_W-1:0] r_cur_row, w_cur_row_nxt;
    logic [COL_W-1:0] r_cur_col, w_cur_col_nxt;
    logic [ROW_W-1:0] r_clr_row, w_clr_row_nxt;
    logic [COL_W-1:0] r_clr_col, w_clr_col_nxt;
    logic             r_pend_v, w_pend_v_nxt;
    logic [7:0]       r_pend, w_pend_nxt;
    logic             r_ovf, w_ovf_nxt;
    logic [7:0]       r_rd_char;

    logic [7:0]       r_ram [DEPTH];

    logic             w_we;
    logic [AW-1:0]    w_waddr;
    logic [7:0]       w_wdata;
    logic [7:0]       w_src;
    logic             w_newline;
    logic             w_rd_ok;
    logic [AW-1:0]    w_rd_addr;

    // The pending slot always has priority over a fresh character.
    assign w_src     = r_pend_v ? r_pend : char;
    assign w_rd_ok   = (rd_row <= LAST_ROW) && (rd_col <= LAST_COL);
    assign w_rd_addr = addr_of(rd_row, rd_col);

    always_comb begin
        w_state_nxt   = r_state;
        w_cur_row_nxt = r_cur_row;
        w_cur_col_nxt = r_cur_col;
        w_clr_row_nxt = r_clr_row;
        w_clr_col_nxt = r_clr_col;
        w_pend_v_nxt  = r_pend_v;
        w_pend_nxt    = r_pend;
        w_ovf_nxt     = r_ovf;
        w_we          = 1'b0;
        w_waddr       = addr_of(r_cur_row, r_cur_col);
        w_wdata       = w_src;
        w_newline     = 1'b0;

        case (r_state)
            S_CLR_ALL: begin
                w_we          = 1'b1;
                w_waddr       = addr_of(r_clr_row, r_clr_col);
                w_wdata       = BLANK;
                w_cur_row_nxt = '0;
                w_cur_col_nxt = '0;
                if (r_clr_col == LAST_COL) begin
                    w_clr_col_nxt = '0;
                    if (r_clr_row == LAST_ROW) begin
                        w_clr_row_nxt = '0;
                        w_state_nxt   = S_IDLE;
                    end else begin
                        w_clr_row_nxt = r_clr_row + 1'b1;
                    end
                end else begin
                    w_clr_col_nxt = r_clr_col + 1'b1;
                end
            end
            S_CLR_LINE: begin
                // The cursor already points at the new row during the clear.
                w_we    = 1'b1;
                w_waddr = addr_of(r_cur_row, r_clr_col);
                w_wdata = BLANK;
                if (r_clr_col == LAST_COL) begin
                    w_clr_col_nxt = '0;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_clr_col_nxt = r_clr_col + 1'b1;
                end
            end
            default: begin
                if (r_pend_v || en) begin
                    if (w_src == CH_NUL) begin
                        w_state_nxt   = S_CLR_ALL;
                        w_clr_row_nxt = '0;
                        w_clr_col_nxt = '0;
                        w_cur_row_nxt = '0;
                        w_cur_col_nxt = '0;
                        w_ovf_nxt     = 1'b0;
                    end else if (w_src == CH_CR) begin
                        w_newline = 1'b1;
                    end else begin
                        w_we = 1'b1;
                        if (r_cur_col == LAST_COL) begin
                            w_newline = 1'b1;
                        end else begin
                            w_cur_col_nxt = r_cur_col + 1'b1;
                        end
                    end
                end
            end
        endcase

        if (w_newline) begin
            w_cur_col_nxt = '0;
            w_cur_row_nxt = (r_cur_row == LAST_ROW) ? '0 : r_cur_row + 1'b1;
            w_clr_col_nxt = '0;
            w_state_nxt   = S_CLR_LINE;
        end

        if (r_state != S_IDLE) begin
            if (en) begin
                if (!r_pend_v) begin
                    w_pend_nxt   = char;
                    w_pend_v_nxt = 1'b1;
                end else begin
                    w_ovf_nxt = 1'b1;
                end
            end
        end else if (r_pend_v) begin
            // The slot is drained this cycle, so a simultaneous arrival refills it.
            if (en) begin
                w_pend_nxt = char;
            end else begin
                w_pend_v_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_CLR_ALL;
            r_cur_row <= '0;
            r_cur_col <= '0;
            r_clr_row <= '0;
            r_clr_col <= '0;
            r_pend_v  <= 1'b0;
            r_pend    <= '0;
            r_ovf     <= 1'b0;
            r_rd_char <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cur_row <= w_cur_row_nxt;
            r_cur_col <= w_cur_col_nxt;
            r_clr_row <= w_clr_row_nxt;
            r_clr_col <= w_clr_col_nxt;
            r_pend_v  <= w_pend_v_nxt;
            r_pend    <= w_pend_nxt;
            r_ovf     <= w_ovf_nxt;
            // Reads the value held before any write on the same edge.
            r_rd_char <= w_rd_ok ? r_ram[w_rd_addr] : BLANK;
        end
    end

    // The RAM itself is never reset; the post-reset screen clear fills it.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_ram[w_waddr] <= w_wdata;
        end
    end

    assign rd_char    = r_rd_char;
    assign cursor_row = r_cur_row;
    assign cursor_col = r_cur_col;
    assign busy       = (r_state != S_IDLE);
    assign overflow   = r_ovf;

endmodule

// File: tb/tb_uart_text_buffer.sv
// tb/tb_uart_text_buffer.sv - self-checking bench for uart_text_buffer
module tb_uart_text_buffer;

    localparam int COLS  = 40;
    localparam int ROWS  = 15;
    localparam int COL_W = 6;
    localparam int ROW_W = 4;
    localparam int DEPTH = ROWS * COLS;

    logic             clk;
    logic             rst_n;
    logic [7:0]       char;
    logic             en;
    logic [ROW_W-1:0] rd_row;
    logic [COL_W-1:0] rd_col;
    logic [7:0]       rd_char;
    logic [ROW_W-1:0] cursor_row;
    logic [COL_W-1:0] cursor_col;
    logic             busy;
    logic             overflow;

    uart_text_buffer #(
        .COLS(COLS), .ROWS(ROWS), .COL_W(COL_W), .ROW_W(ROW_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .char(char), .en(en),
        .rd_row(rd_row), .rd_col(rd_col), .rd_char(rd_char),
        .cursor_row(cursor_row), .cursor_col(cursor_col),
        .busy(busy), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0] c;
        int         row;
        int         col;
        bit         bsy;
    } vec_t;

    vec_t       vecs [6];
    logic [7:0] m_ram [DEPTH];
    int         m_row;
    int         m_col;
    logic [7:0] sb [$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c);
        char = c;
        en   = 1'b1;
        tick();
        en   = 1'b0;
    endtask

    task automatic wait_idle(input int lim, output int n);
        n = 0;
        while (busy && n < lim) begin
            tick();
            n++;
        end
        if (busy) chk("wait_idle_timeout", 1, 0);
    endtask

    function automatic void m_clear_row(input int r);
        for (int c = 0; c < COLS; c++) m_ram[r*COLS + c] = 8'd32;
    endfunction

    function automatic void m_newline();
        m_col = 0;
        m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
        m_clear_row(m_row);
    endfunction

    function automatic void m_putc(input logic [7:0] c);
        if (c == 8'd0) begin
            for (int a = 0; a < DEPTH; a++) m_ram[a] = 8'd32;
            m_row = 0;
            m_col = 0;
        end else if (c == 8'd13) begin
            m_newline();
        end else begin
            m_ram[m_row*COLS + m_col] = c;
            if (m_col < COLS - 1) m_col++;
            else m_newline();
        end
    endfunction

    // Pipelined read sweep: each expected value is queued as the address is
    // driven and popped when the registered data appears one edge later.
    task automatic sweep(input string tag);
        logic [7:0] exp;
        sb.delete();
        for (int a = 0; a < DEPTH; a++) begin
            rd_row = ROW_W'(a / COLS);
            rd_col = COL_W'(a % COLS);
            sb.push_back(m_ram[a]);
            tick();
            exp = sb.pop_front();
            chk($sformatf("%s_rd(%0d,%0d)", tag, a / COLS, a % COLS), int'(rd_char), int'(exp));
        end
    endtask

    task automatic chk_cursor(input string tag, input int r, input int c);
        chk({tag, "_row"}, int'(cursor_row), r);
        chk({tag, "_col"}, int'(cursor_col), c);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        vecs[0] = '{c: 8'd72,  row: 0, col: 1, bsy: 1'b0};
        vecs[1] = '{c: 8'd105, row: 0, col: 2, bsy: 1'b0};
        vecs[2] = '{c: 8'd13,  row: 1, col: 0, bsy: 1'b1};
        vecs[3] = '{c: 8'd66,  row: 1, col: 1, bsy: 1'b0};
        vecs[4] = '{c: 8'd0,   row: 0, col: 0, bsy: 1'b1};
        vecs[5] = '{c: 8'd67,  row: 0, col: 1, bsy: 1'b0};

        rst_n = 1'b0;
        en = 1'b0;
        char = 8'd0;
        rd_row = '0;
        rd_col = '0;
        for (int a = 0; a < DEPTH; a++) m_ram[a] = 8'd32;
        m_row = 0;
        m_col = 0;

        repeat (3) tick();
        chk("rst_rd_char", int'(rd_char), 0);
        chk_cursor("rst", 0, 0);
        chk("rst_busy", int'(busy), 1);
        chk("rst_overflow", int'(overflow), 0);

        rst_n = 1'b1;
        wait_idle(700, n);
        chk("clr_all_cycles", n, 600);
        chk_cursor("after_clr_all", 0, 0);
        sweep("init");

        for (int i = 0; i < 6; i++) begin
            send(vecs[i].c);
            chk_cursor($sformatf("vec%0d", i), vecs[i].row, vecs[i].col);
            chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].bsy));
            m_putc(vecs[i].c);
            wait_idle(700, n);
        end

        send(8'd68);
        m_putc(8'd68);
        rd_row = 4'd0;
        rd_col = 6'd1;
        tick();
        chk("write_to_read", int'(rd_char), 68);

        rd_col = 6'd2;
        char = 8'd69;
        en = 1'b1;
        tick();
        en = 1'b0;
        m_putc(8'd69);
        chk("collision_old", int'(rd_char), 32);
        tick();
        chk("collision_new", int'(rd_char), 69);
        sweep("table");

        send(8'd0);
        m_putc(8'd0);
        wait_idle(700, n);
        chk("nul_clear_cycles", n, 600);
        for (int i = 0; i < 41; i++) begin
            char = 8'(33 + i);
            en = 1'b1;
            tick();
            m_putc(8'(33 + i));
            if (i == 39) begin
                chk("wrap_busy", int'(busy), 1);
                chk_cursor("wrap", 1, 0);
            end
        end
        en = 1'b0;
        wait_idle(100, n);
        chk("wrap_clr_line_rest", n, 39);
        chk_cursor("wrap_idle", 1, 0);
        tick();
        chk_cursor("wrap_41st", 1, 1);
        sweep("wrap");

        for (int k = 0; k < 13; k++) begin
            send(8'd13);
            m_putc(8'd13);
            wait_idle(100, n);
        end
        chk_cursor("row14", 14, 0);
        send(8'd90);
        m_putc(8'd90);
        send(8'd13);
        m_putc(8'd13);
        chk_cursor("row_wrap", 0, 0);
        chk("row_wrap_busy", int'(busy), 1);
        wait_idle(100, n);
        chk("row_wrap_clr_cycles", n, 40);
        sweep("rowwrap");

        send(8'd13);
        send(8'd65);
        chk("pend_no_ovf", int'(overflow), 0);
        send(8'd66);
        chk("drop_ovf", int'(overflow), 1);
        wait_idle(100, n);
        chk("drop_clr_rest", n, 38);
        tick();
        chk_cursor("pend_written", 1, 1);
        chk("ovf_sticky", int'(overflow), 1);
        m_putc(8'd13);
        m_putc(8'd65);
        send(8'd0);
        m_putc(8'd0);
        chk("nul_clears_ovf", int'(overflow), 0);
        wait_idle(700, n);
        chk("nul2_clear_cycles", n, 600);

        send(8'd13);
        send(8'd80);
        wait_idle(100, n);
        send(8'd81);
        chk("first_idle_ovf", int'(overflow), 0);
        tick();
        chk_cursor("first_idle_capture", 1, 2);
        m_putc(8'd13);
        m_putc(8'd80);
        m_putc(8'd81);
        sweep("pend");

        send(8'd13);
        send(8'd88);
        send(8'd89);
        chk("pre_reset_ovf", int'(overflow), 1);
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_cursor("mid_reset", 0, 0);
        chk("mid_reset_busy", int'(busy), 1);
        chk("mid_reset_ovf", int'(overflow), 0);
        chk("mid_reset_rd_char", int'(rd_char), 0);
        tick();
        rst_n = 1'b1;
        wait_idle(700, n);
        chk("restart_clr_cycles", n, 600);
        tick();
        chk_cursor("slot_discarded", 0, 0);
        for (int a = 0; a < DEPTH; a++) m_ram[a] = 8'd32;
        m_row = 0;
        m_col = 0;
        sweep("reset2");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
